// File: rtl/ro_meas_pkg.sv
// Shared definitions for the ring-oscillator frequency meter.
//   meas_state_e : measurement FSM states
//   DEF_*        : default widths and depths
//   sat_add      : increment-by-one that sticks at a caller-supplied ceiling
package ro_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LATCH   = 2'd2
  } meas_state_e;

  localparam int DEF_NUM_CH   = 8;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_WIN_W    = 32;
  localparam int DEF_SYNC_STG = 2;

  // Operands are widened to 64 bits so one function serves every counter width;
  // callers pass their all-ones value as max_val and truncate the result.
  function automatic logic [63:0] sat_add(input logic [63:0] val,
                                          input logic [63:0] max_val,
                                          input logic        inc);
    if (inc && (val != max_val)) return val + 64'd1;
    return val;
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Single-channel synchronizer and rising-edge detector for one RO input.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   ro_async    : asynchronous (pre-divided) ring-oscillator signal
//   edge_pulse  : one clk-wide pulse per rising edge of ro_async
module ro_edge_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ro_async,
  output logic edge_pulse
);

  logic [SYNC_STG-1:0] sync_p0;
  logic                prev_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
    end else begin
      // stage 0: metastability chain, bit 0 faces the asynchronous input
      sync_p0 <= {sync_p0[SYNC_STG-2:0], ro_async};
      // stage 1: delayed copy of the settled level for edge detection
      prev_p1 <= sync_p0[SYNC_STG-1];
    end
  end

  assign edge_pulse = sync_p0[SYNC_STG-1] & ~prev_p1;

endmodule

// File: rtl/ro_freq_meter.sv
// Multi-channel ring-oscillator frequency meter. Counts rising edges of each
// RO input over a programmable gate window and publishes all channel counts
// as one snapshot over a valid/ready handshake.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   ro_in        : asynchronous RO inputs, one per channel
//   ch_en        : channel enable mask, captured at window start
//   win_len      : gate length in clk cycles (0 behaves as 1), captured at start
//   mode_cont    : 1 = back-to-back windows, 0 = single shot
//   start, stop  : start pulse (IDLE only) / abort to IDLE without snapshot
//   pause        : freezes the window counter and edge counting
//   freq, sat    : snapshot counts (ch i at [i*CNT_W +: CNT_W]) and saturation flags
//   freq_valid   : snapshot available, freq_ready : consumer accepts it
//   overrun      : sticky, a snapshot was dropped because the previous one was pending
//   busy         : not IDLE
module ro_freq_meter
  import ro_meas_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int WIN_W    = DEF_WIN_W,
  parameter int SYNC_STG = DEF_SYNC_STG
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ro_in,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [WIN_W-1:0]        win_len,
  input  logic                    mode_cont,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    pause,
  output logic [NUM_CH*CNT_W-1:0] freq,
  output logic [NUM_CH-1:0]       sat,
  output logic                    freq_valid,
  input  logic                    freq_ready,
  output logic                    overrun,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  meas_state_e       state;
  logic [WIN_W-1:0]  win_cnt;
  logic [WIN_W-1:0]  win_load;
  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] pulse;
  logic [CNT_W-1:0]  cnt [NUM_CH];

  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] v,
                                                input logic             inc);
    return CNT_W'(sat_add(64'(v), 64'(CNT_MAX), inc));
  endfunction

  // A zero-length window is stretched to one cycle so the FSM always terminates.
  assign win_load = (win_len == '0) ? {{(WIN_W-1){1'b0}}, 1'b1} : win_len;
  assign busy     = (state != IDLE);

  // edge path: synchronizer + rising-edge detector per channel
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ro_edge_sync #(.SYNC_STG(SYNC_STG)) u_sync (
      .clk        (clk),
      .reset      (reset),
      .ro_async   (ro_in[g]),
      .edge_pulse (pulse[g])
    );
  end

  // control + counting: FSM, gate window, saturating counters, snapshot regs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      win_cnt    <= '0;
      en_q       <= '0;
      freq       <= '0;
      sat        <= '0;
      freq_valid <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      // Consumer handshake; a LATCH below may re-assert valid in the same cycle.
      if (freq_valid && freq_ready) freq_valid <= 1'b0;

      if (stop) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              win_cnt <= win_load;
              en_q    <= ch_en;
              for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
              state   <= MEASURE;
            end
          end
          MEASURE: begin
            if (!pause) begin
              win_cnt <= win_cnt - 1'b1;
              for (int i = 0; i < NUM_CH; i++)
                if (en_q[i]) cnt[i] <= cnt_step(cnt[i], pulse[i]);
              if (win_cnt == {{(WIN_W-1){1'b0}}, 1'b1}) state <= LATCH;
            end
          end
          LATCH: begin
            // Only overwrite the snapshot if the consumer is not still holding it.
            if (!freq_valid || freq_ready) begin
              for (int i = 0; i < NUM_CH; i++) begin
                freq[i*CNT_W +: CNT_W] <= cnt[i];
                sat[i]                 <= (cnt[i] == CNT_MAX);
              end
              freq_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            if (mode_cont) begin
              win_cnt <= win_load;
              en_q    <= ch_en;
              for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
              state   <= MEASURE;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
module tb_ro_freq_meter;

  localparam int NCH  = 8;
  localparam int CW   = 8;
  localparam int WW   = 16;
  localparam int SS   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH-1:0]    ro_in = '0;
  logic [NCH-1:0]    ch_en = '0;
  logic [WW-1:0]     win_len = '0;
  logic              mode_cont = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic              freq_ready = 1'b0;
  logic [NCH*CW-1:0] freq;
  logic [NCH-1:0]    sat;
  logic              freq_valid;
  logic              overrun;
  logic              busy;

  int total = 0;
  int bad   = 0;
  int half [NCH];
  int ph   [NCH];

  ro_freq_meter #(.NUM_CH(NCH), .CNT_W(CW), .WIN_W(WW), .SYNC_STG(SS)) dut (
    .clk        (clk),
    .reset      (reset),
    .ro_in      (ro_in),
    .ch_en      (ch_en),
    .win_len    (win_len),
    .mode_cont  (mode_cont),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .freq       (freq),
    .sat        (sat),
    .freq_valid (freq_valid),
    .freq_ready (freq_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // RO sources: square waves, channel c toggles every half[c] clk cycles (0 = idle low)
  initial begin
    for (int c = 0; c < NCH; c++) ph[c] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (half[c] == 0) ro_in[c] = 1'b0;
        else begin
          ph[c] = ph[c] + 1;
          if (ph[c] >= half[c]) begin
            ph[c] = 0;
            ro_in[c] = ~ro_in[c];
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // A rising edge first sampled at clock k is credited to the clock k+SS;
  // a window counts pulses on its first max(win_len,1) unpaused clocks,
  // then the snapshot is taken on the following clock.
  logic [NCH-1:0] hist [SS+2];
  bit             m_busy, m_latch, m_valid, m_ovr;
  int             m_rem;
  logic [NCH-1:0] m_en;
  int             m_cnt  [NCH];
  int             m_freq [NCH];
  logic [NCH-1:0] m_sat;

  task automatic open_window();
    m_busy = 1'b1;
    m_rem  = (win_len == '0) ? 1 : int'(win_len);
    m_en   = ch_en;
    for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] pul;
    bit old_valid;
    if (reset) begin
      for (int k = 0; k < SS + 2; k++) hist[k] = '0;
      m_busy = 0; m_latch = 0; m_valid = 0; m_ovr = 0; m_rem = 0;
      m_en = '0; m_sat = '0;
      for (int c = 0; c < NCH; c++) begin m_cnt[c] = 0; m_freq[c] = 0; end
      return;
    end
    for (int k = SS + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = ro_in;
    pul = hist[SS] & ~hist[SS+1];
    old_valid = m_valid;
    if (m_valid && freq_ready) m_valid = 0;
    if (stop) begin
      m_busy = 0; m_latch = 0;
    end else if (!m_busy) begin
      if (start) open_window();
    end else if (m_latch) begin
      if (!old_valid || freq_ready) begin
        for (int c = 0; c < NCH; c++) begin
          m_freq[c] = m_cnt[c];
          m_sat[c]  = (m_cnt[c] == CMAX);
        end
        m_valid = 1;
      end else m_ovr = 1;
      m_latch = 0;
      if (mode_cont) open_window();
      else m_busy = 0;
    end else if (!pause) begin
      for (int c = 0; c < NCH; c++)
        if (m_en[c] && pul[c] && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
      m_rem = m_rem - 1;
      if (m_rem == 0) m_latch = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  function automatic logic [NCH*CW-1:0] m_pack();
    logic [NCH*CW-1:0] r;
    int v;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      v = m_freq[c];
      r[c*CW +: CW] = v[CW-1:0];
    end
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic int fch(input int c);
    return int'(freq[c*CW +: CW]);
  endfunction

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check("ctl{ovr,busy,valid}", 64'({overrun, busy, freq_valid}),
            64'({m_ovr, m_busy, m_valid}));
      if (m_valid) begin
        check("snap_freq", 64'(freq), 64'(m_pack()));
        check("snap_sat", 64'(sat), 64'(m_sat));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic consume();
    freq_ready = 1'b1;
    tick();
    freq_ready = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    while (!freq_valid && n < maxc) begin tick(); n++; end
    if (!freq_valid) begin
      total++; bad++;
      $display("FAIL wait_valid: no snapshot within %0d cycles", maxc);
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (busy && n < maxc) begin tick(); n++; end
    if (busy) begin
      total++; bad++;
      $display("FAIL wait_idle: still busy after %0d cycles", maxc);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, n0;
    logic [NCH*CW-1:0] saved;
    for (int c = 0; c < NCH; c++) half[c] = 0;
    repeat (3) tick();
    check("reset_state", 64'({freq, sat, freq_valid, overrun, busy}), 64'd0);
    check("reset_sat", 64'(sat), 64'd0);
    reset = 1'b0;
    tick();

    // T1: ch0 at clk/8, 800-cycle single shot
    half[0] = 4; ch_en = 8'h01; win_len = 16'd800; mode_cont = 1'b0;
    pulse_start();
    wait_valid(2000, n);
    check_rng("t1_freq0", fch(0), 99, 101);
    check("t1_busy_after", 64'(busy), 64'd0);
    repeat (5) tick();
    check("t1_valid_held", 64'(freq_valid), 64'd1);
    consume();
    check("t1_valid_drop", 64'(freq_valid), 64'd0);

    // T2: only channels 0 and 2 enabled, all toggling
    for (int c = 0; c < NCH; c++) half[c] = 2 + (c % 4);
    ch_en = 8'b0000_0101; win_len = 16'd200;
    pulse_start();
    wait_valid(500, n);
    check("t2_ch0_nonzero", 64'(fch(0) != 0), 64'd1);
    check("t2_ch2_nonzero", 64'(fch(2) != 0), 64'd1);
    for (int c = 0; c < NCH; c++)
      if (c != 0 && c != 2) check("t2_disabled_zero", 64'(fch(c)), 64'd0);
    check("t2_sat", 64'(sat), 64'd0);
    consume();

    // T3: ch1 at clk/4 for 1100 cycles -> 275 edges, saturates at 255
    for (int c = 0; c < NCH; c++) half[c] = 0;
    half[1] = 2; ch_en = 8'h02; win_len = 16'd1100;
    pulse_start();
    wait_valid(2000, n);
    check("t3_freq1_sat", 64'(fch(1)), 64'd255);
    check("t3_sat_flags", 64'(sat), 64'h02);
    consume();

    // T4: continuous, consumer stalled -> first snapshot held, overrun set
    half[0] = 3; ch_en = 8'h01; win_len = 16'd50; mode_cont = 1'b1;
    pulse_start();
    wait_valid(200, n);
    saved = freq;
    repeat (60) tick();
    check("t4_overrun", 64'(overrun), 64'd1);
    check("t4_held_freq", 64'(freq), 64'(saved));
    check("t4_held_valid", 64'(freq_valid), 64'd1);
    freq_ready = 1'b1;
    repeat (60) tick();
    mode_cont = 1'b0;
    wait_idle(200);
    tick();
    freq_ready = 1'b0;
    tick();

    // T5: 20-cycle pause mid-window stretches the gate to 120 cycles
    half[0] = 4; ch_en = 8'h01; win_len = 16'd100;
    pulse_start();
    repeat (40) tick();
    pause = 1'b1;
    repeat (20) tick();
    pause = 1'b0;
    wait_valid(200, n0);
    check("t5_latch_time", 64'(60 + n0), 64'd121);
    check_rng("t5_freq0", fch(0), 12, 13);
    consume();

    // T6a: reset mid-measure clears everything, including sticky overrun
    ch_en = 8'hff; win_len = 16'd200;
    for (int c = 0; c < NCH; c++) half[c] = 3;
    pulse_start();
    repeat (30) tick();
    reset = 1'b1;
    tick();
    check("t6_reset_out", 64'({freq_valid, overrun, busy}), 64'd0);
    check("t6_reset_freq", 64'(freq), 64'd0);
    check("t6_reset_sat", 64'(sat), 64'd0);
    reset = 1'b0;
    tick();

    // T6b: stop mid-window keeps the pending snapshot untouched
    ch_en = 8'h01; win_len = 16'd30;
    pulse_start();
    wait_valid(100, n);
    saved = freq;
    pulse_start();
    repeat (10) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t6_stop_busy", 64'(busy), 64'd0);
    check("t6_stop_freq", 64'(freq), 64'(saved));
    check("t6_stop_valid", 64'(freq_valid), 64'd1);
    check("t6_stop_ovr", 64'(overrun), 64'd0);
    consume();

    // Random traffic, checked every cycle by the model compare
    for (int it = 0; it < 25; it++) begin
      for (int c = 0; c < NCH; c++)
        half[c] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 7));
      ch_en     = NCH'($urandom_range(0, 255));
      win_len   = WW'($urandom_range(0, 40));
      mode_cont = ($urandom_range(0, 2) == 0);
      pulse_start();
      n = int'($urandom_range(30, 120));
      for (int k = 0; k < n; k++) begin
        pause      = ($urandom_range(0, 7) == 0);
        freq_ready = ($urandom_range(0, 1) == 1);
        stop       = ($urandom_range(0, 150) == 0);
        start      = ($urandom_range(0, 20) == 0);
        if ($urandom_range(0, 9) == 0) win_len = WW'($urandom_range(0, 40));
        if ($urandom_range(0, 9) == 0) ch_en = NCH'($urandom_range(0, 255));
        tick();
      end
      pause = 1'b0; stop = 1'b0; start = 1'b0; mode_cont = 1'b0;
      wait_idle(500);
      consume();
    end

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
